// File: rtl/bus_arbiter_pkg.sv
// Shared FSM encoding and constants for bus_arbiter and its watchdog.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  // Pipeline hold vectors, bit order {wb,mem,ex,id,if,pc}
  localparam logic [5:0]  StallNone = 6'b000000;
  localparam logic [5:0]  StallIf   = 6'b000111;
  localparam logic [5:0]  StallMem  = 6'b011111;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [3:0]  SelWord   = 4'b1111;

endpackage

// File: rtl/bus_arbiter_wdt.sv
// bus_wdt: counts stalled bus cycles and flags expiry on the LIMIT-th one.
// Only built when BUS_TIMEOUT_EN is defined.
`ifdef BUS_TIMEOUT_EN
module bus_wdt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

  // count holds the number of earlier waiting cycles, so this is cycle LIMIT
  assign expired = en && (count == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bus between the fetch and data ports, data side wins.
// Define BUS_TIMEOUT_EN to add a watchdog that aborts transactions never acked.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic        bus_err
);

  state_t state;
  logic   discard;
  logic   idle_free, grant_mem, grant_if, done, discard_now, expired;

  // The finishing requester still holds req during its ack cycle; skip it
  assign idle_free   = (state == IDLE) && !if_ack && !mem_ack;
  assign grant_mem   = idle_free && mem_req;
  assign grant_if    = idle_free && !mem_req && if_req && !flush;
  assign done        = bus_ack || expired;
  assign discard_now = discard || flush;

`ifdef BUS_TIMEOUT_EN
  logic err_pulse;

  bus_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_mem || grant_if),
    .en      (bus_req && !bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_pulse <= 1'b0;
    else
      err_pulse <= expired;
  end

  assign bus_err = err_pulse;
`else
  // No watchdog: transactions wait forever and bus_err is constant low
  assign expired = 1'b0;
  assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      discard   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= ZeroWord;
      bus_wdata <= ZeroWord;
      bus_sel   <= 4'b0000;
      if_rdata  <= ZeroWord;
      mem_rdata <= ZeroWord;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grant_mem) begin
            state     <= MEM_BUSY;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_sel   <= mem_sel;
          end else if (grant_if) begin
            state     <= IF_BUSY;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= ZeroWord;
            bus_sel   <= SelWord;
          end
        end
        IF_BUSY: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            discard <= 1'b0;
            if (!discard_now) begin
              if_ack   <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : ZeroWord;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (done) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            mem_ack   <= 1'b1;
            mem_rdata <= bus_ack ? bus_rdata : ZeroWord;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall = StallNone;
    if (mem_req && !mem_ack)
      stall = StallMem;
    else if (if_req && !if_ack)
      stall = StallIf;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter with a transaction-level model.
module tb_bus_arbiter;

  logic        clk, rst;
  logic        if_req, mem_req, mem_we, bus_ack, flush;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ack, mem_ack, bus_req, bus_we, bus_err;
  logic [3:0]  bus_sel;
  logic [5:0]  stall;

  int checks = 0;
  int errors = 0;

  // bus slave program, in expected service order
  int          sw[2];
  logic [31:0] sd[2];
  int          nsl, sidx, wcnt;
  bit          slave_on;

  logic [31:0] exp_if_rdata, exp_mem_rdata;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .flush(flush), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_step();
    if (bus_ack) begin
      bus_ack = 1'b0;
      sidx++;
      wcnt = 0;
    end else if (bus_req && slave_on && sidx < nsl) begin
      if (wcnt == sw[sidx]) begin
        bus_ack   = 1'b1;
        bus_rdata = sd[sidx];
      end else begin
        wcnt++;
      end
    end
  endtask

  // Tick n counts cycles after the requests rise. A lone request acks at 2+w;
  // a queued IF waits out the MEM ack cycle plus one idle cycle.
  task automatic run_txn(input bit use_if, input bit use_mem,
                         input logic [31:0] ia, input logic [31:0] ma,
                         input logic [31:0] md, input logic [3:0] ms, input bit mwe,
                         input int wi, input int wm,
                         input logic [31:0] ri, input logic [31:0] rm);
    int tm, ti, ifs, last;
    logic [5:0] exp_stall;
    tm   = use_mem ? 2 + wm : -1;
    ifs  = use_mem ? tm + 2 : 1;
    ti   = use_if ? ifs + 1 + wi : -1;
    last = ((ti > tm) ? ti : tm) + 1;
    nsl = 0; sidx = 0; wcnt = 0; slave_on = 1'b1;
    if (use_mem) begin sw[nsl] = wm; sd[nsl] = rm; nsl++; end
    if (use_if)  begin sw[nsl] = wi; sd[nsl] = ri; nsl++; end
    if_req = use_if; if_addr = ia;
    mem_req = use_mem; mem_addr = ma; mem_wdata = md; mem_sel = ms; mem_we = mwe;
    for (int n = 1; n <= last; n++) begin
      tick();
      check("mem_ack", mem_ack, n == tm);
      check("if_ack", if_ack, n == ti);
      exp_stall = (n < tm) ? 6'b011111 : (n < ti) ? 6'b000111 : 6'b000000;
      check("stall", stall, exp_stall);
      if (use_mem && n == 1) begin
        check("mem_bus_req", bus_req, 1);
        check("mem_bus_we", bus_we, mwe);
        check("mem_bus_addr", bus_addr, ma);
        check("mem_bus_wdata", bus_wdata, md);
        check("mem_bus_sel", bus_sel, ms);
      end
      if (use_if && n == ifs) begin
        check("if_bus_req", bus_req, 1);
        check("if_bus_we", bus_we, 0);
        check("if_bus_addr", bus_addr, ia);
        check("if_bus_sel", bus_sel, 4'b1111);
      end
      if (use_mem && use_if && n == tm + 1) check("gap_bus_req", bus_req, 0);
      if (n == tm) begin check("mem_rdata", mem_rdata, rm); exp_mem_rdata = rm; end
      if (n == ti) begin check("if_rdata", if_rdata, ri); exp_if_rdata = ri; end
      slave_step();
      if (n == tm) mem_req = 1'b0;
      if (n == ti) if_req = 1'b0;
    end
    check("if_rdata_hold", if_rdata, exp_if_rdata);
    check("mem_rdata_hold", mem_rdata, exp_mem_rdata);
    $display("txn if=%0d mem=%0d we=%0d wi=%0d wm=%0d ia=%h ma=%h", use_if, use_mem, mwe, wi, wm, ia, ma);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_wdata"}, bus_wdata, 0);
    check({tag, "_bus_sel"}, bus_sel, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_acks"}, {if_ack, mem_ack}, 0);
    check({tag, "_bus_err"}, bus_err, 0);
  endtask

  initial begin
    clk = 0; rst = 1; flush = 0; bus_ack = 0; bus_rdata = 0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
    nsl = 0; sidx = 0; wcnt = 0; slave_on = 1;
    exp_if_rdata = 0; exp_mem_rdata = 0;
    #2 rst = 0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    tick();

    // fetch on a zero-wait bus
    run_txn(1, 0, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 32'h3401_0020, 0);
    // simultaneous requests, data side first
    run_txn(1, 1, 32'h0000_0104, 32'h10, 32'hDEAD_BEEF, 4'b0011, 1, 0, 0, 32'h1111_2222, 32'hCAFE_0001);

    // flushed fetch: completes on the bus but is discarded
    if_req = 1; if_addr = 32'h0000_0200;
    nsl = 1; sidx = 0; wcnt = 0; sw[0] = 3; sd[0] = 32'h5555_AAAA;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check("flush_if_ack", if_ack, 0);
      if (n == 1) check("flush_bus_req_on", bus_req, 1);
      if (n >= 5) check("flush_bus_req_off", bus_req, 0);
      slave_step();
      if (n == 1) begin flush = 1; if_req = 0; end
      if (n == 2) flush = 0;
    end
    check("flush_if_rdata", if_rdata, exp_if_rdata);
    $display("txn flushed fetch ia=00000200");

    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 2);
      run_txn(k != 1, k != 0, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, $urandom);
    end

    // reset in the middle of a transaction
    slave_on = 0; nsl = 0;
    mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'h1234_5678; mem_sel = 4'b1111;
    tick();
    check("rst_pre_bus_req", bus_req, 1);
    #2 rst = 0;
    #1 check_all_zero("midrst");
    mem_req = 0;
    @(negedge clk) rst = 1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 0;
    check("stale_ack_mem_ack", mem_ack, 0);
    tick();
    check("stale_ack_mem_ack2", mem_ack, 0);
    check("stale_ack_mem_rdata", mem_rdata, 0);
    check("stale_ack_bus_req", bus_req, 0);
    exp_if_rdata = 0; exp_mem_rdata = 0;
    $display("txn reset mid-transaction");

    // bus never acks
    mem_req = 1; mem_we = 0; mem_addr = 32'h80; mem_sel = 4'b1111;
`ifdef BUS_TIMEOUT_EN
    for (int n = 1; n <= 11; n++) begin
      tick();
      check("to_bus_err", bus_err, n == 9);
      check("to_mem_ack", mem_ack, n == 9);
      check("to_bus_req", bus_req, n <= 8);
      if (n == 9) begin
        check("to_mem_rdata", mem_rdata, 0);
        check("to_stall", stall, 6'b000000);
        mem_req = 0;
      end
    end
    $display("txn timeout abort");
`else
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n % 10 == 0) check("wait_bus_req", bus_req, 1);
      check("wait_bus_err", bus_err, 0);
      check("wait_mem_ack", mem_ack, 0);
    end
    #2 rst = 0; mem_req = 0;
    @(negedge clk) rst = 1;
    tick();
    $display("txn indefinite wait then reset");
`endif
    run_txn(1, 1, 32'h300, 32'h44, 32'h0BAD_F00D, 4'b1000, 0, 1, 2, 32'h7777_0000, 32'h8888_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  clock (rising edge); rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have fetch-side ports: if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetched instruction; if_ack out 1 fetch complete.
REQ-003 SHALL have data-side ports: mem_req in 1; mem_we in 1; mem_addr in 32; mem_wdata in 32; mem_sel in 4 byte enables; mem_rdata out 32; mem_ack out 1.
REQ-004 SHALL have bus-side ports: bus_req out 1; bus_we out 1; bus_addr out 32; bus_wdata out 32; bus_sel out 4; bus_rdata in 32; bus_ack in 1.
REQ-005 SHALL have control ports: flush in 1 (discard the pending fetch); stall out 6 ({wb,mem,ex,id,if,pc} hold vector); bus_err out 1 (timeout pulse).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles bus_req waits for bus_ack.

Function
REQ-007 SHALL implement a three-state FSM: IDLE, IF_BUSY, MEM_BUSY.
REQ-008 In IDLE with mem_req=1 it SHALL enter MEM_BUSY, else with if_req=1 and flush=0 it SHALL enter IF_BUSY; if both requests are asserted, MEM wins.
REQ-009 On grant, it SHALL register the winner's address/we/wdata/sel onto the bus_* outputs and assert bus_req from the next cycle until bus_ack; in IF_BUSY, bus_we=0 and bus_sel=4'b1111.
REQ-010 On bus_ack=1 in a BUSY state, it SHALL register bus_rdata into the owner's rdata, pulse the owner's ack for exactly one cycle on the next cycle, deassert bus_req, and return to IDLE.
REQ-011 Minimum latency SHALL be 2 cycles (req to ack) with a zero-wait-state bus.
REQ-012 Each requester SHALL hold its req and operands until its ack; a new grant SHALL NOT be issued in the ack cycle (one IDLE cycle between transactions).
REQ-013 stall SHALL be 6'b011111 whenever mem_req=1 and mem_ack=0, else 6'b000111 whenever if_req=1 and if_ack=0, else 6'b000000; this is combinational from the request inputs and the registered acks.
REQ-014 flush=1 during IF_BUSY SHALL NOT abort the bus cycle; it SHALL set a discard flag so that completion updates no if_rdata and pulses no if_ack; the flag SHALL clear on return to IDLE.
REQ-015 if_rdata and mem_rdata SHALL hold their last value between transactions.

Reset
REQ-016 While rst=0: FSM=IDLE, all bus_* outputs=0, if_rdata=mem_rdata=32'h0, acks=0, bus_err=0, discard flag=0, timeout counter=0, asynchronously.
REQ-017 Reset asserted mid-transaction SHALL abandon it; a bus_ack arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-018 With BUS_TIMEOUT_EN defined, a counter SHALL count cycles with bus_req=1 and bus_ack=0; reaching TIMEOUT_CYCLES SHALL drop bus_req, pulse bus_err for one cycle, pulse the owner's ack with rdata=32'h0, and return to IDLE; the counter SHALL clear on every grant.
REQ-019 Without BUS_TIMEOUT_EN, no counter logic SHALL exist, bus_err SHALL be tied to 0, and a transaction SHALL wait indefinitely.

Structure
REQ-020 State encodings, the stall vector constants (StallNone, StallIf, StallMem), and ZeroWord SHALL live in the shared defines file.
REQ-021 The timeout counter SHALL be a sub-module bus_wdt (inputs clk, rst, clr, en; output expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-022 if_req=1, if_addr=32'h0000_0100, bus_ack on the first bus_req cycle with bus_rdata=32'h3401_0020 -> if_ack pulses at cycle 2 with if_rdata=32'h3401_0020; stall=6'b000111 until then.
REQ-023 if_req and mem_req rise together, mem_we=1, mem_addr=32'h10, mem_wdata=32'hDEAD_BEEF, mem_sel=4'b0011 -> MEM is served first with bus_we=1 and bus_sel=4'b0011, stall=6'b011111; IF is granted one IDLE cycle after mem_ack.
REQ-024 flush=1 one cycle into a fetch, bus_ack after 3 wait states -> no if_ack, if_rdata unchanged, FSM back in IDLE.
REQ-025 rst=0 asserted while bus_req=1 -> all outputs 0 immediately; a subsequent bus_ack produces no ack.
REQ-026 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus_ack is never asserted -> after 8 bus_req cycles bus_err pulses once, mem_ack pulses with mem_rdata=32'h0, and stall clears; without the macro, bus_req stays high for 100 cycles.
